acc_op_sequencer: RTL
=====================

ACC_OP_SEQUENCER -- requirements
Module: acc_op_sequencer

Interface
REQ-001 Parameter: WIDTH, default 4, sets the accumulator and operand width in bits.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  an operation request is presented.
REQ-005 in_ready  output  1  the sequencer can accept a request; equals (state == IDLE).
REQ-006 in_op  input  4  opcode: 0 LOAD, 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR, 9 SSHL, 10 SSHR; 11-15 illegal.
REQ-007 in_data  input  WIDTH  right-hand operand (b), or the shift amount for opcodes 7-10.
REQ-008 acc  output  WIDTH  accumulator register (c), registered.
REQ-009 done  output  1  one-cycle pulse: the accepted operation has completed.
REQ-010 err  output  1  one-cycle pulse, coincident with done, for an illegal opcode.
REQ-011 busy  output  1  a multi-cycle operation is in progress; equals (state != IDLE).

Function
REQ-012 Request acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1 (edge E0); in_valid while busy is ignored and not queued.
REQ-013 States SHALL be IDLE, MUL and SHIFT; the block SHALL return to IDLE after every operation.
REQ-014 Single-cycle ops SHALL be LOAD, ADD, SUB, AND, OR, XOR and illegal opcodes.
REQ-015 A single-cycle op SHALL write acc at E0 and hold state IDLE.
REQ-016 For a single-cycle op, done SHALL be high for exactly the cycle after E0.
REQ-017 Back-to-back single-cycle ops SHALL be accepted on consecutive edges, with one done pulse per op.
REQ-018 Operation results: LOAD acc=b; ADD acc+b; SUB acc-b; AND, OR and XOR bitwise.
REQ-019 All arithmetic SHALL be unsigned modulo 2^WIDTH, with no carry, borrow or overflow output.
REQ-020 MUL SHALL latch b at E0 and enter MUL.
REQ-021 MUL SHALL perform one shift-add step on each edge E1..E_WIDTH and write acc = (acc*b) mod 2^WIDTH at E_WIDTH.
REQ-022 MUL SHALL return to IDLE at E_WIDTH, with done high in the following cycle.
REQ-023 acc SHALL hold its pre-op value during MUL.
REQ-024 Shift ops SHALL use k = min(in_data, WIDTH).
REQ-025 A shift with k=0 SHALL be single-cycle with acc unchanged.
REQ-026 A shift with k>0 SHALL enter SHIFT at E0 and shift acc by one bit on each of edges E1..Ek.
REQ-027 A shift with k>0 SHALL return to IDLE at Ek, with done high in the following cycle.
REQ-028 SHL and SSHL SHALL shift left with zero fill.
REQ-029 SHR and SSHR SHALL shift right with zero fill, since operands are unsigned.
REQ-030 A shift amount >= WIDTH SHALL give acc=0 after WIDTH cycles.
REQ-031 An illegal opcode SHALL leave acc unchanged and pulse err together with done.
REQ-032 done and err SHALL never be high for two consecutive cycles belonging to the same operation.

Reset
REQ-033 While rst_n=0: state=IDLE, acc=0, done=0, err=0, busy=0, in_ready=1, and internal counters and latched operands cleared.
REQ-034 Reset asserted mid-MUL or mid-SHIFT SHALL abort the operation immediately, with no done pulse after release.
REQ-035 The first request SHALL be accepted on the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-036 LOAD 4'h3 then ADD 4'hE on consecutive edges -> acc 4'h3 then 4'h1; done high two consecutive cycles; busy never high.
REQ-037 LOAD 4'h3, MUL 4'h7 -> in_ready low 4 cycles; acc stays 4'h3 until E4, then 4'h5; one done pulse.
REQ-038 LOAD 4'h9, SHR 4'h2 -> acc 4'h4 then 4'h2, busy 2 cycles; LOAD 4'h9, SSHR 4'h1 -> acc 4'h4 (zero fill).
REQ-039 LOAD 4'hF, SHL 4'hF -> busy exactly 4 cycles; acc 4'hE, 4'hC, 4'h8, 4'h0.
REQ-040 LOAD 4'h0, SUB 4'h1 -> acc 4'hF; opcode 4'hB -> acc stays 4'hF, err and done pulse together for one cycle.
REQ-041 rst_n low two cycles into MUL -> acc 4'h0 at once; after release in_ready=1, no done; a new LOAD is accepted next edge.

Source files
------------

// File: rtl/acc_op_sequencer.sv
// rtl/acc_op_sequencer.sv - accumulator operation sequencer with multi-cycle MUL and shifts
//
// Accepts one operation per request handshake and applies it to an internal
// accumulator. LOAD/ADD/SUB/AND/OR/XOR and illegal opcodes complete in one
// cycle. MUL runs a WIDTH-step shift-add. Shifts move one bit per cycle.
// Every accepted operation produces a one-cycle done pulse.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - operation request present
//   in_ready  - sequencer idle and able to accept a request
//   in_op     - opcode (0 LOAD .. 10 SSHR, 11-15 illegal)
//   in_data   - right-hand operand or shift amount
//   acc       - accumulator register
//   done      - one-cycle completion pulse
//   err       - one-cycle pulse with done for an illegal opcode
//   busy      - multi-cycle operation in progress

module acc_op_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] acc,
    output logic             done,
    output logic             err,
    output logic             busy
);

    // Counter must hold values 0..WIDTH (shift count up to WIDTH).
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_LOAD = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_SSHL = 4'd9;
    localparam logic [3:0] OP_SSHR = 4'd10;

    localparam logic [WIDTH:0]  W_EXT  = (WIDTH + 1)'(WIDTH);
    localparam logic [CW-1:0]   W_CNT  = CW'(WIDTH);
    localparam logic [CW-1:0]   MUL_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [WIDTH-1:0] acc_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] mul_a, mul_a_n;     // multiplicand, shifted left each step
    logic [WIDTH-1:0] mul_b, mul_b_n;     // multiplier, shifted right each step
    logic [WIDTH-1:0] prod, prod_n;       // running partial product
    logic             dir_left, dir_left_n;
    logic             done_n, err_n;

    logic [CW-1:0]    shift_k;
    logic [WIDTH-1:0] mul_sum;

    // Shift amounts saturate at WIDTH: beyond that the result is all zero anyway.
    assign shift_k = ({1'b0, in_data} >= W_EXT) ? W_CNT : CW'(in_data);

    // One shift-add step: add the multiplicand when the current multiplier LSB is set.
    assign mul_sum = prod + (mul_b[0] ? mul_a : '0);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            cnt      <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            prod     <= '0;
            dir_left <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            mul_a    <= mul_a_n;
            mul_b    <= mul_b_n;
            prod     <= prod_n;
            dir_left <= dir_left_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n    = state;
        acc_n      = acc;
        cnt_n      = cnt;
        mul_a_n    = mul_a;
        mul_b_n    = mul_b;
        prod_n     = prod;
        dir_left_n = dir_left;
        done_n     = 1'b0;
        err_n      = 1'b0;

        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    case (in_op)
                        OP_LOAD: begin acc_n = in_data;       done_n = 1'b1; end
                        OP_ADD:  begin acc_n = acc + in_data; done_n = 1'b1; end
                        OP_SUB:  begin acc_n = acc - in_data; done_n = 1'b1; end
                        OP_AND:  begin acc_n = acc & in_data; done_n = 1'b1; end
                        OP_OR:   begin acc_n = acc | in_data; done_n = 1'b1; end
                        OP_XOR:  begin acc_n = acc ^ in_data; done_n = 1'b1; end
                        OP_MUL: begin
                            mul_a_n = acc;
                            mul_b_n = in_data;
                            prod_n  = '0;
                            cnt_n   = '0;
                            state_n = S_MUL;
                        end
                        OP_SHL, OP_SSHL, OP_SHR, OP_SSHR: begin
                            if (shift_k == '0) begin
                                done_n = 1'b1;
                            end else begin
                                cnt_n      = shift_k;
                                dir_left_n = (in_op == OP_SHL) || (in_op == OP_SSHL);
                                state_n    = S_SHIFT;
                            end
                        end
                        default: begin
                            done_n = 1'b1;
                            err_n  = 1'b1;
                        end
                    endcase
                end
            end

            S_MUL: begin
                prod_n  = mul_sum;
                mul_a_n = mul_a << 1;
                mul_b_n = mul_b >> 1;
                cnt_n   = cnt + CNT_ONE;
                // acc keeps its pre-op value until the final step lands the product.
                if (cnt == MUL_LAST) begin
                    acc_n   = mul_sum;
                    cnt_n   = '0;
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end

            S_SHIFT: begin
                acc_n = dir_left ? (acc << 1) : (acc >> 1);
                cnt_n = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Status outputs
    always_comb begin
        in_ready = (state == S_IDLE);
        busy     = (state != S_IDLE);
    end

endmodule
